// File: rtl/cnt_burst_sched_pkg.sv
// Shared types for the burst scheduler: one-hot FSM encoding and client ids.
// Imported by the arbiter and the scheduler top.
package cnt_burst_sched_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        BURST = 4'b0010,
        GAP   = 4'b0100,
        ERR   = 4'b1000
    } state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer moves to the loser when a grant is taken.
// Winner is combinational from req and the registered pointer.
module rr_arb2
    import cnt_burst_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] winner
);

    // favoured client index: 0 after reset
    logic prio;

    always_comb begin
        winner = 2'b00;
        unique case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = (prio == CLIENT1) ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= CLIENT0;
        end else if (advance) begin
            prio <= ~winner[1];
        end
    end

endmodule

// File: rtl/cnt_burst_sched.sv
// Shares one up/down counter between two clients as length-N bursts.
// Sticky overflow from the counter parks the scheduler in ERR until reset.
module cnt_burst_sched
    import cnt_burst_sched_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             err,
    output logic             cnt_act,
    output logic             cnt_up_dwn_n,
    input  logic             cnt_ovflw
);

    state_t           state;
    state_t           state_nxt;
    logic             idx_q;
    logic             dir_q;
    logic [LEN_W-1:0] rem_q;

    logic [1:0]       win;
    logic             win_idx;
    logic             win_dir;
    logic [LEN_W-1:0] win_len;
    logic             advance;
    logic [1:0]       idx_oh;

    assign win_idx = win[1];
    assign win_dir = dir[win_idx];
    assign win_len = win_idx ? len1 : len0;
    assign advance = (state == IDLE) && (req != 2'b00) && !cnt_ovflw;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .winner  (win)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = (win_len != '0) ? BURST : GAP;
                end
            end
            BURST: begin
                if (rem_q == LEN_W'(1)) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
        // overflow wins over every other transition
        if (cnt_ovflw) begin
            state_nxt = ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx_q <= CLIENT0;
            dir_q <= 1'b0;
            rem_q <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                idx_q <= win_idx;
                dir_q <= win_dir;
                rem_q <= win_len;
            end else if (state == BURST && rem_q != '0) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

    assign idx_oh       = idx_q ? 2'b10 : 2'b01;
    assign gnt          = (state == BURST) ? idx_oh : 2'b00;
    assign done         = (state == GAP) ? idx_oh : 2'b00;
    assign busy         = (state != IDLE);
    assign err          = (state == ERR);
    assign cnt_act      = (state == BURST);
    assign cnt_up_dwn_n = (state == BURST) && dir_q;

endmodule

// File: tb/tb_cnt_burst_sched.sv
// Directed bench for the burst scheduler with a small counter model attached.
// Each scenario task drives inputs and checks outputs 1 time unit after clk rises.
module tb_cnt_burst_sched;

    localparam int LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             err;
    logic             cnt_act;
    logic             cnt_up_dwn_n;
    logic             cnt_ovflw;

    logic [7:0]       count;
    int               vectors;
    int               miscompares;

    cnt_burst_sched #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .dir          (dir),
        .len0         (len0),
        .len1         (len1),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .err          (err),
        .cnt_act      (cnt_act),
        .cnt_up_dwn_n (cnt_up_dwn_n),
        .cnt_ovflw    (cnt_ovflw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // attached up/down counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (cnt_act) begin
            count <= cnt_up_dwn_n ? count + 8'd1 : count - 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst_n = 1'b0;
        req = 2'b00;
        dir = 2'b00;
        len0 = '0;
        len1 = '0;
        cnt_ovflw = 1'b0;
        #12;
        obs = {gnt, done, busy, err, cnt_act, cnt_up_dwn_n};
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset outs got %b want %b", obs, 8'h00);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset idle got busy=%b cnt=%0d want 0/0", busy, count);
        end
    endtask

    task automatic test_single_burst();
        logic [5:0] obs;
        req = 2'b01;
        dir = 2'b01;
        len0 = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            req = 2'b00;
            obs = {gnt, cnt_act, cnt_up_dwn_n, done};
            vectors++;
            if (obs !== 6'b01_1_1_00) begin
                miscompares++;
                $display("FAIL single burst cyc%0d got %b want %b", i, obs, 6'b011100);
            end
        end
        step();
        obs = {gnt, cnt_act, cnt_up_dwn_n, done};
        vectors++;
        if (obs !== 6'b00_0_0_01 || count !== 8'd3) begin
            miscompares++;
            $display("FAIL single gap got %b cnt=%0d want 000001 cnt=3", obs, count);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || done !== 2'b00) begin
            miscompares++;
            $display("FAIL single idle got busy=%b done=%b want 0 00", busy, done);
        end
    endtask

    task automatic test_down_burst();
        logic [5:0] obs;
        req = 2'b10;
        dir = 2'b00;
        len1 = 4'd2;
        for (int i = 0; i < 2; i++) begin
            step();
            req = 2'b00;
            obs = {gnt, cnt_act, cnt_up_dwn_n, done};
            vectors++;
            if (obs !== 6'b10_1_0_00) begin
                miscompares++;
                $display("FAIL down burst cyc%0d got %b want %b", i, obs, 6'b101000);
            end
        end
        step();
        vectors++;
        if (done !== 2'b10 || cnt_act !== 1'b0 || count !== 8'd1) begin
            miscompares++;
            $display("FAIL down gap got done=%b act=%b cnt=%0d want 10 0 1", done, cnt_act, count);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL down idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt [12];
        logic [1:0] exp_done [12];
        exp_gnt  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                     2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        exp_done = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                     2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
        req = 2'b11;
        dir = 2'b11;
        len0 = 4'd1;
        len1 = 4'd1;
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (gnt !== exp_gnt[i] || done !== exp_done[i]) begin
                miscompares++;
                $display("FAIL contention cyc%0d got gnt=%b done=%b want %b %b",
                         i, gnt, done, exp_gnt[i], exp_done[i]);
            end
        end
        req = 2'b00;
        step();
        vectors++;
        if (busy !== 1'b0 || count !== 8'd5) begin
            miscompares++;
            $display("FAIL contention end got busy=%b cnt=%0d want 0 5", busy, count);
        end
    endtask

    task automatic test_zero_len();
        req = 2'b10;
        len1 = 4'd0;
        dir = 2'b10;
        step();
        req = 2'b00;
        vectors++;
        if (done !== 2'b10 || gnt !== 2'b00 || cnt_act !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL zero len got done=%b gnt=%b act=%b busy=%b want 10 00 0 1",
                     done, gnt, cnt_act, busy);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || done !== 2'b00 || count !== 8'd5) begin
            miscompares++;
            $display("FAIL zero idle got busy=%b done=%b cnt=%0d want 0 00 5", busy, done, count);
        end
    endtask

    task automatic test_overflow();
        req = 2'b01;
        dir = 2'b01;
        len0 = 4'd5;
        step();
        req = 2'b00;
        vectors++;
        if (gnt !== 2'b01 || cnt_act !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf first got gnt=%b act=%b want 01 1", gnt, cnt_act);
        end
        step();
        cnt_ovflw = 1'b1;
        step();
        vectors++;
        if (err !== 1'b1 || cnt_act !== 1'b0 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf err got err=%b act=%b gnt=%b done=%b busy=%b want 1 0 00 00 1",
                     err, cnt_act, gnt, done, busy);
        end
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (err !== 1'b1 || gnt !== 2'b00 || done !== 2'b00 || cnt_act !== 1'b0) begin
                miscompares++;
                $display("FAIL ovf lock cyc%0d got err=%b gnt=%b done=%b act=%b want 1 00 00 0",
                         i, err, gnt, done, cnt_act);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] obs;
        rst_n = 1'b0;
        #3;
        cnt_ovflw = 1'b0;
        rst_n = 1'b1;
        step();
        req = 2'b01;
        dir = 2'b01;
        len0 = 4'd4;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        obs = {gnt, done, busy, err, cnt_act, cnt_up_dwn_n};
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL async reset got %b want %b", obs, 8'h00);
        end
        len0 = 4'd2;
        #2;
        rst_n = 1'b1;
        step();
        vectors++;
        if (gnt !== 2'b01 || cnt_act !== 1'b1 || cnt_up_dwn_n !== 1'b1) begin
            miscompares++;
            $display("FAIL post reset got gnt=%b act=%b up=%b want 01 1 1", gnt, cnt_act, cnt_up_dwn_n);
        end
        req = 2'b00;
        step();
        step();
        vectors++;
        if (done !== 2'b01 || count !== 8'd2) begin
            miscompares++;
            $display("FAIL post reset gap got done=%b cnt=%0d want 01 2", done, count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_burst();
        test_down_burst();
        test_contention();
        test_zero_len();
        test_overflow();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
